// File: rtl/countdown_counter.sv
// Loadable down-counter with one-cycle terminal pulse and optional auto-reload; load latency 1 cycle.
// No backpressure: load wins over decrement, and enable only gates decrements while counting.
module countdown_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] reload_nxt;
    logic             done_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            count  <= ZERO;
            reload <= ZERO;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            reload <= reload_nxt;
            done   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload;
        done_nxt   = 1'b0;
        if (load) begin
            // A zero load parks the counter instead of arming a zero-length interval.
            count_nxt  = load_value;
            reload_nxt = load_value;
            state_nxt  = (load_value != ZERO) ? COUNT : IDLE;
        end else if (state == COUNT && enable) begin
            if (count == ONE) begin
                done_nxt = 1'b1;
                if (auto_reload) begin
                    count_nxt = reload;
                end else begin
                    count_nxt = ZERO;
                    state_nxt = IDLE;
                end
            end else if (count == ZERO) begin
                state_nxt = IDLE;
            end else begin
                count_nxt = count - ONE;
            end
        end
    end

    assign busy = (state == COUNT);

endmodule

// File: tb/tb_countdown_counter.sv
// Table-driven check of countdown_counter (WIDTH=4) with an expected-output queue.
module tb_countdown_counter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_value = 4'd0;
    logic       enable = 1'b0;
    logic       auto_reload = 1'b0;
    logic [3:0] count;
    logic       busy;
    logic       done;

    countdown_counter #(.WIDTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .load        (load),
        .load_value  (load_value),
        .enable      (enable),
        .auto_reload (auto_reload),
        .count       (count),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic       ld;
        logic [3:0] lv;
        logic       en;
        logic       ar;
        logic [3:0] e_count;
        logic       e_busy;
        logic       e_done;
        string      name;
    } vec_t;

    typedef struct {
        logic [3:0] e_count;
        logic       e_busy;
        logic       e_done;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic add(input logic rst, input logic ld, input logic [3:0] lv, input logic en,
                       input logic ar, input logic [3:0] ec, input logic eb, input logic ed,
                       input string name);
        vec_t v;
        v.rst = rst; v.ld = ld; v.lv = lv; v.en = en; v.ar = ar;
        v.e_count = ec; v.e_busy = eb; v.e_done = ed; v.name = name;
        vecs.push_back(v);
    endtask

    // Drive inputs away from the edge, queue the expectation, compare just after the edge.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clock);
        reset = v.rst; load = v.ld; load_value = v.lv; enable = v.en; auto_reload = v.ar;
        e.e_count = v.e_count; e.e_busy = v.e_busy; e.e_done = v.e_done; e.name = v.name;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        got = exp_q.pop_front();
        n_checks++;
        if (count === got.e_count && busy === got.e_busy && done === got.e_done) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got count=%0d busy=%b done=%b, want count=%0d busy=%b done=%b",
                     got.name, count, busy, done, got.e_count, got.e_busy, got.e_done);
        end
    endtask

    initial begin
        // reset held with load asserted
        add(1, 1, 9, 0, 0, 0, 0, 0, "reset_a");
        add(1, 1, 9, 0, 0, 0, 0, 0, "reset_b");
        // basic countdown
        add(0, 1, 5, 0, 0, 5, 1, 0, "basic_load");
        add(0, 0, 0, 1, 0, 4, 1, 0, "basic_4");
        add(0, 0, 0, 1, 0, 3, 1, 0, "basic_3");
        add(0, 0, 0, 1, 0, 2, 1, 0, "basic_2");
        add(0, 0, 0, 1, 0, 1, 1, 0, "basic_1");
        add(0, 0, 0, 1, 0, 0, 0, 1, "basic_done");
        add(0, 0, 0, 1, 0, 0, 0, 0, "basic_hold_a");
        add(0, 0, 0, 1, 0, 0, 0, 0, "basic_hold_b");
        // enable gaps, then zero load
        add(0, 1, 3, 0, 0, 3, 1, 0, "gap_load");
        add(0, 0, 0, 1, 0, 2, 1, 0, "gap_en1");
        add(0, 0, 0, 0, 0, 2, 1, 0, "gap_en0a");
        add(0, 0, 0, 0, 0, 2, 1, 0, "gap_en0b");
        add(0, 0, 0, 1, 0, 1, 1, 0, "gap_en1b");
        add(0, 0, 0, 1, 0, 0, 0, 1, "gap_done");
        add(0, 1, 0, 1, 0, 0, 0, 0, "zero_load");
        add(0, 0, 0, 1, 0, 0, 0, 0, "zero_idle");
        // auto-reload period 3
        add(0, 1, 3, 0, 1, 3, 1, 0, "auto_load");
        for (int k = 0; k < 3; k++) begin
            add(0, 0, 0, 1, 1, 2, 1, 0, "auto_2");
            add(0, 0, 0, 1, 1, 1, 1, 0, "auto_1");
            add(0, 0, 0, 1, 1, 3, 1, 1, "auto_wrap");
        end
        // auto-reload period 1
        add(0, 1, 1, 0, 1, 1, 1, 0, "auto1_load");
        for (int k = 0; k < 3; k++) add(0, 0, 0, 1, 1, 1, 1, 1, "auto1_every");
        // load on the terminal edge
        add(0, 1, 4, 0, 0, 4, 1, 0, "ovr_load");
        add(0, 0, 0, 1, 0, 3, 1, 0, "ovr_3");
        add(0, 0, 0, 1, 0, 2, 1, 0, "ovr_2");
        add(0, 0, 0, 1, 0, 1, 1, 0, "ovr_1");
        add(0, 1, 7, 1, 0, 7, 1, 0, "ovr_term_load");
        add(0, 0, 0, 0, 0, 7, 1, 0, "ovr_hold");
        // reset mid-count
        add(0, 1, 4, 0, 0, 4, 1, 0, "mrst_load");
        add(0, 0, 0, 1, 0, 3, 1, 0, "mrst_3");
        add(0, 0, 0, 1, 0, 2, 1, 0, "mrst_2");
        add(1, 0, 0, 1, 0, 0, 0, 0, "mrst_reset");
        add(0, 0, 0, 1, 0, 0, 0, 0, "mrst_after");

        foreach (vecs[i]) step(vecs[i]);

        // full range: load 15, done must arrive on exactly the 15th enabled edge
        begin
            vec_t v;
            int   done_edge;
            v.rst = 0; v.ld = 1; v.lv = 15; v.en = 0; v.ar = 0;
            v.e_count = 15; v.e_busy = 1; v.e_done = 0; v.name = "full_load";
            step(v);
            done_edge = -1;
            for (int k = 1; k <= 17; k++) begin
                v.ld = 0; v.lv = 0; v.en = 1;
                v.e_count = (k >= 15) ? 4'd0 : 4'(15 - k);
                v.e_busy  = (k < 15);
                v.e_done  = (k == 15);
                v.name    = "full_step";
                step(v);
                if (done === 1'b1 && done_edge < 0) done_edge = k;
            end
            n_checks++;
            if (done_edge == 15) n_pass++;
            else $display("FAIL full_done_edge: got %0d enabled edges, want 15", done_edge);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/countdown_counter.md
# countdown_counter

Loadable down-counter that runs in the opposite direction to the team's 4-bit JK ripple/synchronous up-counter. It accepts a start value, decrements once per enabled clock, and raises a one-cycle `done` pulse on reaching zero. An optional auto-reload mode turns it into a periodic tick generator. Lab timing and sequencing blocks use it as a programmable interval source.

## Interface
- `WIDTH`, default 4: count register width. Legal values are ≥2.
- `clock`  input  1  sole clock. All state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset, sampled on the rising edge of `clock`.
- `load`  input  1  captures `load_value` into the count and reload registers.
- `load_value`  input  WIDTH  start value (unsigned).
- `enable`  input  1  permits one decrement per cycle while running.
- `auto_reload`  input  1  sampled at the terminal decrement. 1 means restart from the reload register.
- `count`  output  WIDTH  current count (registered).
- `busy`  output  1  high while the FSM is in COUNT (registered).
- `done`  output  1  one-cycle terminal pulse (registered).

## Operation
- Reset state: FSM in IDLE, `count`=0, reload register=0, `busy`=0, `done`=0.
- FSM has two states: IDLE and COUNT. `busy` equals (state == COUNT).
- Priority at every edge: `reset` > `load` > `enable` decrement > hold.
- `load`=1 with `load_value`≠0, from any state:
  - `count` and reload register take `load_value`.
  - Next state is COUNT, `done`=0.
- `load`=1 with `load_value`=0:
  - `count`=0 and reload register=0.
  - Next state is IDLE, `done`=0. No pulse is generated.
- In COUNT with `enable`=1 and `count`>1: `count` ← `count`−1, `done`=0.
- In COUNT with `enable`=1 and `count`=1 (terminal decrement), `done` ← 1 for exactly one cycle, and:
  - if `auto_reload`=0: `count` ← 0, next state IDLE;
  - if `auto_reload`=1: `count` ← reload register, stay in COUNT.
- In COUNT with `enable`=0: `count` holds, `done`=0.
- In IDLE: `enable` is ignored and `count` holds.
- Arithmetic is unsigned, WIDTH bits. `count` never underflows, because the 1→0 transition is the only way to reach 0 while running.
- `load` on the same edge as a terminal decrement: `load` wins and `done` stays 0.
- `reset` mid-count: returns to reset state on that edge. Any pending `done` is suppressed.

## Timing
- Load latency is 1 cycle. After the loading edge, `count`=`load_value` and `busy`=1.
- With `enable` held high after loading N, the terminal decrement occurs on the N-th enabled edge after load. `done` is high during the cycle following that edge.
- Non-auto mode: `busy` drops on the same edge that raises `done`. `count` reads 0 in that cycle.
- Auto-reload mode with `enable` continuously high: `done` period is N cycles, and `count` cycles N…1.
- `done` is never high for two consecutive cycles, except in auto-reload with N=1. In that case it is high every cycle.
- Maximum load is 2^WIDTH−1. With WIDTH=4, a load of 15 takes 15 enabled cycles.

## Test plan
- Reset: hold `reset` 2 cycles while `load`=1 and `load_value`=9 → `count`=0, `busy`=0, `done`=0 throughout.
- Basic countdown: load 5, then `enable`=1 and `auto_reload`=0 → `count` reads 5,4,3,2,1,0. `done`=1 only in the cycle where `count`=0, with `busy` falling on that same edge. Afterwards `count` holds at 0 with `enable` still high.
- Enable gaps and zero load: load 3, then enable pattern 1,0,0,1,1 → `count` 3,2,2,2,1,0 with a single `done`. Then load 0 → stays IDLE, no `done`.
- Auto-reload: load 3, `auto_reload`=1, `enable`=1 for 9 cycles → `count` 3,2,1,3,2,1,3,2,1 and `done` pulses 3 cycles apart (3 pulses). Load 1 in auto mode → `done` high every cycle.
- Override cases:
  - load 4, run to `count`=1, then assert `load`=1 with `load_value`=7 on the terminal edge → `count`=7, `done`=0, `busy`=1.
  - Mid-count `reset` at `count`=2 → `count`=0, `busy`=0 next cycle.
- Full range: load 15 (WIDTH=4) and count to 0 → exactly 15 enabled cycles to `done`, with no underflow to 15 afterwards.
